register_file_pipe: RTL and testbench

REGISTER_FILE_PIPE -- requirements
Module: register_file_pipe

---
 rtl/register_file_pipe.sv | 154 +++++++++++++++
 tb/tb_register_file_pipe.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/register_file_pipe.sv
// Register file with zeroing sweep, 1-cycle registered reads with write bypass,
// and per-register pending-producer (busy) tracking with a live reservation count.
module register_file_pipe #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned ADDR_W   = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   output logic              ready,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_addr,
   output logic              busy1,
   output logic              busy2,
   output logic [ADDR_W:0]   busy_cnt
);

   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0]  NUM_REGS_X = CNT_W'(NUM_REGS);
   localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(NUM_REGS - 1);

   typedef enum logic [0:0] {INIT = 1'b0, RUN = 1'b1} state_t;

   state_t              state, state_next;
   logic [ADDR_W-1:0]   ptr, ptr_next;
   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0] busy, busy_next;

   logic                run_ok, do_wr, do_rsv, cnt_inc, cnt_dec;
   logic [CNT_W-1:0]    cnt_next;
   logic [DATA_W-1:0]   rd1_next, rd2_next;
   logic                busy1_next, busy2_next;

   // Register 0 and out-of-range addresses are never written, reserved or read
   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return (a != '0) && ({1'b0, a} < NUM_REGS_X);
   endfunction

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= INIT;
         ptr   <= '0;
      end else begin
         state <= state_next;
         ptr   <= ptr_next;
      end
   end

   // Next-state: sweep every register once, then run until a clear request
   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      unique case (state)
         INIT: begin
            ptr_next = ptr + ADDR_W'(1);
            if (ptr == LAST_PTR) begin
               state_next = RUN;
               ptr_next   = '0;
            end
         end
         RUN: begin
            if (clr) begin
               state_next = INIT;
               ptr_next   = '0;
            end
         end
         default: begin
            state_next = INIT;
            ptr_next   = '0;
         end
      endcase
   end

   // Output/datapath decode: busy update, count delta, read data with bypass
   always_comb begin
      run_ok     = (state == RUN) && !clr;
      do_wr      = run_ok && we && addr_ok(waddr);
      do_rsv     = run_ok && rsv_en && addr_ok(rsv_addr);
      busy_next  = busy;
      cnt_inc    = 1'b0;
      cnt_dec    = 1'b0;
      rd1_next   = '0;
      rd2_next   = '0;
      busy1_next = 1'b0;
      busy2_next = 1'b0;

      if (do_wr) begin
         busy_next[waddr] = 1'b0;
         cnt_dec = busy[waddr] && !(do_rsv && (rsv_addr == waddr));
      end
      if (do_rsv) begin
         busy_next[rsv_addr] = 1'b1;
         cnt_inc = !busy[rsv_addr];
      end
      if (!run_ok) begin
         busy_next = '0;
      end
      cnt_next = run_ok ? (busy_cnt + CNT_W'(cnt_inc) - CNT_W'(cnt_dec)) : '0;

      // A clear still returns stored data on that edge; only writes are dropped
      if (state == RUN) begin
         if (addr_ok(ra1)) begin
            rd1_next   = (do_wr && (waddr == ra1)) ? wdata : regs[ra1];
            busy1_next = busy_next[ra1];
         end
         if (addr_ok(ra2)) begin
            rd2_next   = (do_wr && (waddr == ra2)) ? wdata : regs[ra2];
            busy2_next = busy_next[ra2];
         end
      end
   end

   // Storage: zeroed by the sweep, no reset on the array itself
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state == INIT) begin
            regs[ptr] <= '0;
         end else if (do_wr) begin
            regs[waddr] <= wdata;
         end
      end
   end

   // Registered outputs and busy tracking
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy     <= '0;
         busy_cnt <= '0;
         rd1      <= '0;
         rd2      <= '0;
         busy1    <= 1'b0;
         busy2    <= 1'b0;
         ready    <= 1'b0;
      end else begin
         busy     <= busy_next;
         busy_cnt <= cnt_next;
         rd1      <= rd1_next;
         rd2      <= rd2_next;
         busy1    <= busy1_next;
         busy2    <= busy2_next;
         ready    <= (state_next == RUN);
      end
   end

endmodule

// File: tb/tb_register_file_pipe.sv
// Self-checking bench for register_file_pipe: directed scenarios then random
// traffic, compared every cycle against a behavioural model of the file.
module tb_register_file_pipe;

   localparam int unsigned DW = 32;
   localparam int unsigned NR = 32;
   localparam int unsigned AW = 5;

   logic          clk = 1'b0;
   logic          rst_n, clr, ready, we, rsv_en, busy1, busy2;
   logic [AW-1:0] waddr, ra1, ra2, rsv_addr;
   logic [DW-1:0] wdata, rd1, rd2;
   logic [AW:0]   busy_cnt;

   int errors = 0;
   int checks = 0;
   int step_no = 0;
   int n;

   // Behavioural model state
   logic [DW-1:0] mem [NR];
   bit            mbusy [NR];
   int            sweep_left = NR;
   logic [DW-1:0] e_rd1, e_rd2;
   logic          e_b1, e_b2, e_ready;
   int            e_cnt;

   register_file_pipe #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .ready(ready),
      .we(we), .waddr(waddr), .wdata(wdata),
      .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .busy1(busy1), .busy2(busy2), .busy_cnt(busy_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   function automatic bit valid(input logic [AW-1:0] a);
      return (a != '0) && (int'(a) < NR);
   endfunction

   function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
      return valid(a) ? mem[a] : '0;
   endfunction

   function automatic logic rd_busy(input logic [AW-1:0] a);
      return valid(a) ? logic'(mbusy[a]) : 1'b0;
   endfunction

   function automatic int popcount();
      int c = 0;
      foreach (mbusy[i]) c += int'(mbusy[i]);
      return c;
   endfunction

   // Model one rising edge from the currently driven inputs
   task automatic model_edge();
      bit wr, rv;
      if (!rst_n) begin
         sweep_left = NR;
         foreach (mbusy[i]) mbusy[i] = 1'b0;
         e_rd1 = '0; e_rd2 = '0; e_b1 = 1'b0; e_b2 = 1'b0; e_cnt = 0; e_ready = 1'b0;
      end else if (sweep_left > 0) begin
         sweep_left--;
         e_rd1 = '0; e_rd2 = '0; e_b1 = 1'b0; e_b2 = 1'b0; e_cnt = 0;
         e_ready = (sweep_left == 0);
         if (sweep_left == 0) foreach (mem[i]) mem[i] = '0;
      end else if (clr) begin
         e_rd1 = rd_val(ra1);
         e_rd2 = rd_val(ra2);
         foreach (mbusy[i]) mbusy[i] = 1'b0;
         e_b1 = 1'b0; e_b2 = 1'b0; e_cnt = 0; e_ready = 1'b0;
         sweep_left = NR;
      end else begin
         wr = we && valid(waddr);
         rv = rsv_en && valid(rsv_addr);
         e_rd1 = (wr && waddr == ra1) ? wdata : rd_val(ra1);
         e_rd2 = (wr && waddr == ra2) ? wdata : rd_val(ra2);
         if (wr) begin
            mem[waddr]   = wdata;
            mbusy[waddr] = 1'b0;
         end
         if (rv) mbusy[rsv_addr] = 1'b1;
         e_b1 = rd_busy(ra1);
         e_b2 = rd_busy(ra2);
         e_cnt = popcount();
         e_ready = 1'b1;
      end
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s step %0d: observed %0h expected %0h", tag, step_no, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      step_no++;
      check("ready", 64'(ready), 64'(e_ready));
      check("rd1", 64'(rd1), 64'(e_rd1));
      check("rd2", 64'(rd2), 64'(e_rd2));
      check("busy1", 64'(busy1), 64'(e_b1));
      check("busy2", 64'(busy2), 64'(e_b2));
      check("busy_cnt", 64'(busy_cnt), 64'(e_cnt));
   endtask

   task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                        input logic rv, input logic [AW-1:0] ra, input logic c);
      we = w; waddr = wa; wdata = wd; ra1 = a1; ra2 = a2;
      rsv_en = rv; rsv_addr = ra; clr = c;
   endtask

   task automatic wait_ready(input string tag);
      n = 0;
      do begin
         tick();
         n++;
      end while (ready !== 1'b1 && n < 100);
      check(tag, 64'(n), 64'd32);
   endtask

   function automatic logic [AW-1:0] pick_addr();
      return ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 9)) : AW'($urandom);
   endfunction

   initial begin
      rst_n = 1'b0;
      drive(1'b0, '0, '0, '0, '0, 1'b0, '0, 1'b0);
      tick();
      tick();

      // Release with traffic and clr asserted: all ignored during the sweep
      rst_n = 1'b1;
      drive(1'b1, 5'd5, 32'hAAAA_5555, 5'd5, 5'd6, 1'b1, 5'd6, 1'b1);
      wait_ready("ready_latency_reset");

      drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0, 1'b0, '0, 1'b0);
      tick();
      check("bypass_rd1", 64'(rd1), 64'h0000_0000_DEAD_BEEF);
      drive(1'b0, '0, '0, 5'd0, 5'd5, 1'b0, '0, 1'b0);
      tick();
      check("stored_rd2", 64'(rd2), 64'h0000_0000_DEAD_BEEF);

      drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
      tick();
      check("reg0_rd1", 64'(rd1), 64'd0);
      check("reg0_rsv_cnt", 64'(busy_cnt), 64'd0);

      drive(1'b0, '0, '0, 5'd7, 5'd9, 1'b1, 5'd7, 1'b0);
      tick();
      drive(1'b0, '0, '0, 5'd7, 5'd9, 1'b1, 5'd9, 1'b0);
      tick();
      check("rsv_two_cnt", 64'(busy_cnt), 64'd2);
      drive(1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd9, 1'b0, '0, 1'b0);
      tick();
      check("wr7_cnt", 64'(busy_cnt), 64'd1);
      check("wr7_busy1", 64'(busy1), 64'd0);
      drive(1'b1, 5'd9, 32'h0BAD_F00D, 5'd7, 5'd9, 1'b1, 5'd9, 1'b0);
      tick();
      check("wr_rsv9_cnt", 64'(busy_cnt), 64'd1);
      check("wr_rsv9_busy2", 64'(busy2), 64'd1);
      check("wr_rsv9_rd2", 64'(rd2), 64'h0000_0000_0BAD_F00D);

      // Clear sweep zeroes contents and drops reservations
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, AW'(i), 32'h1000_0000 + DW'(i), '0, '0, 1'b0, '0, 1'b0);
         tick();
      end
      drive(1'b0, '0, '0, 5'd1, 5'd3, 1'b1, 5'd3, 1'b0);
      tick();
      drive(1'b1, 5'd2, 32'hCAFE_CAFE, 5'd1, 5'd3, 1'b1, 5'd4, 1'b1);
      tick();
      check("clr_ready", 64'(ready), 64'd0);
      check("clr_cnt", 64'(busy_cnt), 64'd0);
      drive(1'b0, '0, '0, 5'd1, 5'd2, 1'b0, '0, 1'b0);
      wait_ready("ready_latency_clr");
      tick();
      check("clr_rd1_reg1", 64'(rd1), 64'd0);
      check("clr_rd2_reg2", 64'(rd2), 64'd0);
      drive(1'b0, '0, '0, 5'd3, 5'd2, 1'b0, '0, 1'b0);
      tick();
      check("clr_rd1_reg3", 64'(rd1), 64'd0);

      // Reset at sweep pointer 10 restarts the full sweep
      drive(1'b0, '0, '0, '0, '0, 1'b0, '0, 1'b1);
      tick();
      drive(1'b0, '0, '0, '0, '0, 1'b0, '0, 1'b0);
      for (int i = 0; i < 10; i++) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      wait_ready("ready_latency_midsweep");

      // Random traffic with occasional clear and reset
      for (int i = 0; i < 700; i++) begin
         rst_n = ($urandom_range(0, 299) != 0);
         drive(logic'($urandom_range(0, 1)), pick_addr(), DW'($urandom),
               pick_addr(), pick_addr(), logic'($urandom_range(0, 1)), pick_addr(),
               ($urandom_range(0, 119) == 0));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
